// File: rtl/intr_ctrl.sv
// intr_ctrl: prioritized interrupt controller with pending/mask registers and an IDLE/REQ/SERVICE handshake.
// Define INTR_CTRL_EDGE_EN for rising-edge-sensitive irq lines; the default build is level-sensitive.
module intr_ctrl #(
   parameter int N_IRQ = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic             intr_en,
   input  logic             inst_boundary,
   input  logic             iret,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [31:0]      wr_data,
   output logic             intr_req,
   output logic [3:0]       intr_id,
   output logic             in_service,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   localparam logic [1:0]       ADDR_MASK   = 2'd0;
   localparam logic [1:0]       ADDR_CLR    = 2'd1;
   localparam logic [1:0]       ADDR_SET    = 2'd2;
   localparam logic [N_IRQ-1:0] ZERO_VEC    = {N_IRQ{1'b0}};
   localparam logic [N_IRQ-1:0] ONE_HOT_LSB = {{(N_IRQ-1){1'b0}}, 1'b1};

   state_e           state_q;
   logic             intr_req_q;
   logic             in_service_q;
   logic [3:0]       intr_id_q;
   logic [N_IRQ-1:0] pending_q;
   logic [N_IRQ-1:0] pending_d;
   logic [N_IRQ-1:0] mask_q;
   logic [N_IRQ-1:0] mask_d;
   logic [N_IRQ-1:0] eligible_s;
   logic [N_IRQ-1:0] elig_shift_s;
   logic [N_IRQ-1:0] irq_set_s;
   logic [N_IRQ-1:0] sw_set_s;
   logic [N_IRQ-1:0] sw_clr_s;
   logic [N_IRQ-1:0] accept_clr_s;
   logic             id_eligible_s;
   logic             unused_wr_data_s;

   // Lowest index wins: scan from the top so the last hit is the smallest index.
   function automatic logic [3:0] prio_idx(input logic [N_IRQ-1:0] vec);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

`ifdef INTR_CTRL_EDGE_EN
   logic [N_IRQ-1:0] irq_q;

   // Previous irq sample for rising-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= ZERO_VEC;
      end else begin
         irq_q <= irq;
      end
   end

   assign irq_set_s = irq & ~irq_q;
`else
   assign irq_set_s = irq;
`endif

   assign eligible_s       = pending_q & mask_q;
   assign elig_shift_s     = eligible_s >> intr_id_q;
   assign id_eligible_s    = elig_shift_s[0];
   assign unused_wr_data_s = ^wr_data[31:N_IRQ];

   // Register-write decode and pending next state; sets are applied last so they win over clears.
   always_comb begin
      sw_set_s     = ZERO_VEC;
      sw_clr_s     = ZERO_VEC;
      mask_d       = mask_q;
      accept_clr_s = ZERO_VEC;
      if (wr_en) begin
         case (wr_addr)
            ADDR_MASK: mask_d   = wr_data[N_IRQ-1:0];
            ADDR_CLR:  sw_clr_s = wr_data[N_IRQ-1:0];
            ADDR_SET:  sw_set_s = wr_data[N_IRQ-1:0];
            default:   mask_d   = mask_q;
         endcase
      end else begin
         mask_d = mask_q;
      end
      if ((state_q == REQ) && inst_boundary) begin
         accept_clr_s = ONE_HOT_LSB << intr_id_q;
      end else begin
         accept_clr_s = ZERO_VEC;
      end
      pending_d = (pending_q & ~(sw_clr_s | accept_clr_s)) | irq_set_s | sw_set_s;
   end

   // Pending and mask registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= ZERO_VEC;
         mask_q    <= ZERO_VEC;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
      end
   end

   // Request handshake FSM; intr_id is frozen while a request is outstanding.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         intr_req_q   <= 1'b0;
         in_service_q <= 1'b0;
         intr_id_q    <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (intr_en && (eligible_s != ZERO_VEC)) begin
                  state_q    <= REQ;
                  intr_id_q  <= prio_idx(eligible_s);
                  intr_req_q <= 1'b1;
               end
            end
            REQ: begin
               if (inst_boundary) begin
                  state_q      <= SERVICE;
                  intr_req_q   <= 1'b0;
                  in_service_q <= 1'b1;
               end else if (!intr_en || !id_eligible_s) begin
                  state_q    <= IDLE;
                  intr_req_q <= 1'b0;
               end
            end
            SERVICE: begin
               if (iret) begin
                  state_q      <= IDLE;
                  in_service_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               intr_req_q   <= 1'b0;
               in_service_q <= 1'b0;
            end
         endcase
      end
   end

   assign intr_req   = intr_req_q;
   assign intr_id    = intr_id_q;
   assign in_service = in_service_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter N_IRQ, default 4, number of interrupt request lines (2..16).
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port irq  input  N_IRQ  peripheral request lines (UART rx, timer, ...), active-high.
REQ-005 Port intr_en  input  1  global enable from CPU status register (sr.intr_en).
REQ-006 Port inst_boundary  input  1  CPU at instruction boundary, able to take an interrupt this cycle.
REQ-007 Port iret  input  1  one-cycle pulse, CPU executing return-from-interrupt.
REQ-008 Port wr_en  input  1  register write strobe from CPU.
REQ-009 Port wr_addr  input  2  0=MASK, 1=PEND_CLR (write-1-to-clear), 2=PEND_SET (software set), 3=reserved (ignored).
REQ-010 Port wr_data  input  32  write data; bits [N_IRQ-1:0] used.
REQ-011 Port intr_req  output  1  interrupt request to CPU.
REQ-012 Port intr_id  output  4  index of requested/in-service line, zero-extended.
REQ-013 Port in_service  output  1  CPU is inside a handler.
REQ-014 Port pending  output  N_IRQ  current pending register.
REQ-015 Port mask  output  N_IRQ  current mask register (1 = enabled).

Function
REQ-016 Pending bit i SHALL set on a clock edge where the line is asserted per REQ-034/035, or on PEND_SET write with wr_data[i]=1.
REQ-017 Pending bit i SHALL clear on PEND_CLR write with wr_data[i]=1, or on acceptance of line i (REQ-022).
REQ-018 Set and clear of the same bit in one cycle: set wins.
REQ-019 MASK write replaces mask[N_IRQ-1:0] on the next edge.
REQ-020 Eligible vector = pending & mask; priority SHALL be lowest index highest.
REQ-021 FSM states IDLE, REQ, SERVICE; IDLE -> REQ when intr_en=1 and eligible nonzero; intr_id latched to highest-priority eligible index on that edge.
REQ-022 REQ: intr_req=1; inst_boundary=1 -> SERVICE, pending[intr_id] cleared, in_service=1 on same edge.
REQ-023 REQ: if intr_en=0 or eligible[intr_id]=0 (masked/cleared) and inst_boundary=0 -> IDLE (request withdrawn), intr_req low next cycle.
REQ-024 REQ: intr_id SHALL NOT change while in REQ, even if a higher-priority line becomes eligible.
REQ-025 SERVICE: intr_req=0; iret=1 -> IDLE, in_service cleared; no nesting.
REQ-026 iret outside SERVICE SHALL be ignored.
REQ-027 Re-evaluation after SERVICE->IDLE takes one cycle; back-to-back requests see intr_req low for exactly one cycle.
REQ-028 Latency: irq rising at edge k sets pending at edge k; intr_req high after edge k+1 (2nd cycle), given mask and intr_en set.
REQ-029 intr_req, in_service, intr_id SHALL be registered outputs (no combinational path from irq).
REQ-030 Writes to reserved address and bits >= N_IRQ SHALL have no effect.

Reset
REQ-031 reset=1 at a clock edge: state=IDLE, pending=0, mask=0, intr_req=0, in_service=0, intr_id=0, edge-detect history=0.
REQ-032 Reset mid-REQ or mid-SERVICE SHALL abort without side effects; reset overrides all simultaneous writes/irq.
REQ-033 First irq evaluation occurs on the first edge with reset=0.

Configuration
REQ-034 Macro INTR_CTRL_EDGE_EN defined: pending bit set only on rising edge of irq[i] (irq[i]=1, registered irq_q[i]=0); a held line sets pending once.
REQ-035 Macro INTR_CTRL_EDGE_EN undefined: level-sensitive; pending[i] set every edge irq[i]=1, so PEND_CLR while held has no lasting effect; irq_q register not built.

Verification
REQ-036 mask=4'b0010, intr_en=1, irq[1] pulse 1 cycle -> intr_req high 2 cycles later, intr_id=1; inst_boundary -> in_service=1, pending=0; iret -> in_service=0.
REQ-037 mask=4'b1111, irq=4'b1100 same cycle -> intr_id=2 served first; after iret, one cycle low, then intr_id=3.
REQ-038 mask=0, irq[0] pulse -> pending=4'b0001, intr_req stays 0; MASK write 1 -> intr_req high, intr_id=0.
REQ-039 In REQ with intr_id=1, PEND_CLR wr_data=2 and inst_boundary=0 -> IDLE, intr_req 0 next cycle, pending=0.
REQ-040 In SERVICE with pending=4'b0001, reset=1 one cycle -> all outputs 0, pending=0, mask=0.
REQ-041 irq[0] held high 10 cycles, one service + iret -> EDGE_EN: no second request; level: second request with intr_id=0.
